bf16_operand_feeder: RTL and testbench
======================================

BF16_OPERAND_FEEDER -- requirements
Module: bf16_operand_feeder

Interface
REQ-001 Parameter DEPTH, default 4, SHALL set the number of operand-pair FIFO entries (power of two, at least 2).
REQ-002 Parameter HOLD_CYCLES, default 3, SHALL set how many cycles after a sample edge the operands are held unchanged.
REQ-003 clock  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 reset  input  1  SHALL be an asynchronous, active-high reset.
REQ-005 in_valid  input  1  SHALL indicate an operand pair is offered.
REQ-006 in_ready  output  1  SHALL indicate a pair can be accepted.
REQ-007 in_a, in_b  input  16 each  SHALL carry bfloat16 operands.
REQ-008 add_a, add_b  output  16 each  SHALL drive the adder's a and b inputs.
REQ-009 add_ready  input  1  SHALL be the adder's ready flag.
REQ-010 add_sum  input  16  SHALL be the adder's sum.
REQ-011 out_valid  output  1  SHALL flag a held result.
REQ-012 out_ready  input  1  SHALL be the consumer's accept.
REQ-013 out_sum  output  16  SHALL carry the held result.
REQ-014 level  output  clog2(DEPTH)+1  SHALL report FIFO occupancy.
REQ-015 busy  output  1  SHALL be high in any state other than IDLE.

Function
REQ-016 Push SHALL occur when in_valid && in_ready; in_ready SHALL equal !full, and a push SHALL be refused when the FIFO is full, even if a pop occurs in the same cycle.
REQ-017 Simultaneous push and pop on a non-full, non-empty FIFO SHALL leave level unchanged; pointers SHALL wrap modulo DEPTH.
REQ-018 Edge: a sample edge SHALL be a cycle where add_ready is 1 and its registered previous value is 0; add_ready held high SHALL count as one edge only.
REQ-019 FSM states SHALL be IDLE, ISSUE, HOLD, WAIT_RESULT.
REQ-020 IDLE transition: when the FIFO is non-empty and out_valid==0, the FSM SHALL pop the head into add_a/add_b and go to ISSUE; otherwise it SHALL stay in IDLE.
REQ-021 ISSUE transition: on an edge, the FSM SHALL load a counter with HOLD_CYCLES and go to HOLD.
REQ-022 HOLD transition: the counter SHALL decrement each cycle, and the FSM SHALL go to WAIT_RESULT when the counter reaches 0.
REQ-023 HOLD behaviour: edges during HOLD SHALL be ignored.
REQ-024 WAIT_RESULT transition: on an edge, add_sum SHALL be registered into out_sum, out_valid SHALL be set, and the FSM SHALL go to IDLE.
REQ-025 Operand stability: add_a and add_b SHALL change only on an IDLE->ISSUE pop, and SHALL stay stable from ISSUE entry until the next pop.
REQ-026 At most one pair SHALL be in flight.
REQ-027 Latency: out_valid SHALL rise on the cycle after the second edge following the pop.
REQ-028 Output handshake: out_valid SHALL clear on the cycle after out_valid && out_ready, and out_sum SHALL hold its value while out_valid is high.
REQ-029 Back-pressure: while out_valid==1, the FSM SHALL NOT leave IDLE.
REQ-030 Data handling: the block SHALL NOT inspect or modify bfloat16 contents, so NaN and infinity pass through bit-exact.

Reset
REQ-031 Reset SHALL act immediately and clear state to IDLE, the pointers, level and the counter.
REQ-032 Reset SHALL clear add_a=0, add_b=0, out_sum=0, out_valid=0, busy=0 and the registered add_ready to 1, so that a ready already high at release is not an edge.
REQ-033 A reset in any state SHALL discard the FIFO contents and any in-flight pair, and no result SHALL follow.

Structure
REQ-034 Package bf16_pkg SHALL hold BF16_W=16, the state enum and the default DEPTH and HOLD_CYCLES.
REQ-035 The FIFO SHALL be the sub-module bf16_pair_fifo (32-bit entries, full/empty/level); all other logic SHALL be in the top.

Verification
REQ-036 Reset: assert reset mid-cycle -> outputs zero asynchronously, in_ready=1, level=0, busy=0.
REQ-037 Single operation: push (0x3F80,0x4000); the model pulses add_ready and returns 0x4040 at the next pulse -> add_a=0x3F80 and add_b=0x4000 are stable throughout, then out_valid=1 with out_sum=0x4040.
REQ-038 Full FIFO: push 4 pairs with add_ready=0 -> level=4, in_ready=0, and a 5th pair is held until the first pop, then accepted.
REQ-039 Back-pressure: out_ready=0 after the first result -> the second pair is not popped, level is unchanged and out_sum is stable; out_ready=1 -> out_valid drops and the second pair issues.
REQ-040 Ready held high: hold add_ready=1 for 5 cycles -> exactly one edge is counted.
REQ-041 Reset during WAIT_RESULT: assert reset -> out_valid stays 0, level=0, and a later edge produces no result.

Source files
------------

// File: rtl/bf16_pkg.sv
// Shared constants and types for the bfloat16 operand feeder.
package bf16_pkg;

    // Width of one bfloat16 operand or result.
    localparam int BF16_W = 16;

    // Default FIFO depth (operand pairs) and post-edge hold time (cycles).
    localparam int DEFAULT_DEPTH       = 4;
    localparam int DEFAULT_HOLD_CYCLES = 3;

    // Feeder sequencing states.
    typedef enum logic [1:0] {
        ST_IDLE        = 2'd0,
        ST_ISSUE       = 2'd1,
        ST_HOLD        = 2'd2,
        ST_WAIT_RESULT = 2'd3
    } feeder_state_e;

    // One queued operand pair, a in the upper half and b in the lower half.
    typedef struct packed {
        logic [BF16_W-1:0] a;
        logic [BF16_W-1:0] b;
    } bf16_pair_t;

endpackage

// File: rtl/bf16_pair_fifo.sv
// Small FIFO of operand pairs with full/empty flags and an occupancy count.
// The head entry is visible combinationally so the consumer can capture it
// in the same cycle as the pop.
module bf16_pair_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 32
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   push,
    input  logic [WIDTH-1:0]       push_data,
    input  logic                   pop,
    output logic [WIDTH-1:0]       head,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] level
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_LEVEL = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_reg;
    logic [AW-1:0]    rd_ptr_reg;
    logic [AW:0]      count_reg;
    logic             do_push;
    logic             do_pop;

    // A push is refused whenever full, even if a pop happens in the same cycle.
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    assign full  = (count_reg == FULL_LEVEL);
    assign empty = (count_reg == '0);
    assign level = count_reg;
    assign head  = mem[rd_ptr_reg];

    // Storage write; entries need no reset because the pointers define validity.
    always_ff @(posedge clock) begin
        if (do_push) begin
            mem[wr_ptr_reg] <= push_data;
        end
    end

    // Pointer and occupancy bookkeeping; pointers wrap naturally (power-of-two depth).
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_reg <= wr_ptr_reg + AW'(1);
            end
            if (do_pop) begin
                rd_ptr_reg <= rd_ptr_reg + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count_reg <= count_reg + (AW+1)'(1);
                2'b01:   count_reg <= count_reg - (AW+1)'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

endmodule

// File: rtl/bf16_operand_feeder.sv
// Feeds queued bfloat16 operand pairs to a handshake-less adder that signals
// with a level "ready" flag. A rising edge of add_ready starts the hold window,
// the next rising edge after the window delivers the sum. Operand bits are
// never inspected, so NaN/Inf patterns pass through untouched.
module bf16_operand_feeder
    import bf16_pkg::*;
#(
    parameter int DEPTH       = DEFAULT_DEPTH,
    parameter int HOLD_CYCLES = DEFAULT_HOLD_CYCLES
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [BF16_W-1:0]      in_a,
    input  logic [BF16_W-1:0]      in_b,
    output logic [BF16_W-1:0]      add_a,
    output logic [BF16_W-1:0]      add_b,
    input  logic                   add_ready,
    input  logic [BF16_W-1:0]      add_sum,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [BF16_W-1:0]      out_sum,
    output logic [$clog2(DEPTH):0] level,
    output logic                   busy
);

    localparam logic [1:0] IDLE        = ST_IDLE;
    localparam logic [1:0] ISSUE       = ST_ISSUE;
    localparam logic [1:0] HOLD        = ST_HOLD;
    localparam logic [1:0] WAIT_RESULT = ST_WAIT_RESULT;

    localparam int CW = (HOLD_CYCLES < 2) ? 1 : $clog2(HOLD_CYCLES + 1);
    localparam logic [CW-1:0] HOLD_LOAD = CW'(HOLD_CYCLES);

    logic [1:0]    state_reg;
    logic [CW-1:0] hold_cnt_reg;
    logic          ready_prev_reg;
    logic          ready_edge;
    logic          fifo_push;
    logic          fifo_pop;
    logic          fifo_full;
    logic          fifo_empty;
    bf16_pair_t    fifo_head;

    assign in_ready   = !fifo_full;
    assign fifo_push  = in_valid && !fifo_full;
    // Only one pair in flight, and never while a result is still waiting.
    assign fifo_pop   = (state_reg == IDLE) && !fifo_empty && !out_valid;
    assign ready_edge = add_ready && !ready_prev_reg;
    assign busy       = (state_reg != IDLE);

    bf16_pair_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (2 * BF16_W)
    ) u_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (fifo_push),
        .push_data ({in_a, in_b}),
        .pop       (fifo_pop),
        .head      (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .level     (level)
    );

    // Previous add_ready; resets high so a ready already asserted at release is not an edge.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ready_prev_reg <= 1'b1;
        end else begin
            ready_prev_reg <= add_ready;
        end
    end

    // Sequencer: pop, wait first edge, hold, wait second edge; operands only change on a pop.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_reg    <= IDLE;
            hold_cnt_reg <= '0;
            add_a        <= '0;
            add_b        <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (fifo_pop) begin
                        add_a     <= fifo_head.a;
                        add_b     <= fifo_head.b;
                        state_reg <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (ready_edge) begin
                        hold_cnt_reg <= HOLD_LOAD;
                        state_reg    <= HOLD;
                    end
                end
                HOLD: begin
                    // Edges seen here are deliberately ignored.
                    if (hold_cnt_reg <= CW'(1)) begin
                        hold_cnt_reg <= '0;
                        state_reg    <= WAIT_RESULT;
                    end else begin
                        hold_cnt_reg <= hold_cnt_reg - CW'(1);
                    end
                end
                WAIT_RESULT: begin
                    if (ready_edge) begin
                        state_reg <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    // Result register: capture on the delivering edge, hold until the consumer accepts.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            out_valid <= 1'b0;
            out_sum   <= '0;
        end else if ((state_reg == WAIT_RESULT) && ready_edge) begin
            out_valid <= 1'b1;
            out_sum   <= add_sum;
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_bf16_operand_feeder.sv
// Randomized bench for bf16_operand_feeder with a queue-based reference model.
module tb_bf16_operand_feeder;
    import bf16_pkg::*;

    localparam int DEPTH = 4;
    localparam int HOLD  = 3;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] in_a = '0;
    logic [15:0] in_b = '0;
    logic [15:0] add_a;
    logic [15:0] add_b;
    logic        add_ready = 1'b0;
    logic [15:0] add_sum;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [15:0] out_sum;
    logic [2:0]  level;
    logic        busy;

    always #5 clock = ~clock;

    bf16_operand_feeder #(
        .DEPTH       (DEPTH),
        .HOLD_CYCLES (HOLD)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .add_a     (add_a),
        .add_b     (add_b),
        .add_ready (add_ready),
        .add_sum   (add_sum),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .level     (level),
        .busy      (busy)
    );

    // Stand-in adder: any deterministic function of the operands will do,
    // with 1.0 + 2.0 giving the true bfloat16 answer 3.0.
    function automatic logic [15:0] fake_sum(input logic [15:0] a, input logic [15:0] b);
        if (a == 16'h3F80 && b == 16'h4000) return 16'h4040;
        return a ^ {b[7:0], b[15:8]} ^ 16'h0101;
    endfunction

    assign add_sum = fake_sum(add_a, add_b);

    int n_checks = 0;
    int n_fail   = 0;
    int n_results = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: pending pairs, the pair in flight and its progress.
    logic [31:0] m_q[$];
    bit          m_fly;
    logic [31:0] m_pair;
    int          m_stage;   // 0: awaiting first edge, 1: hold window, 2: awaiting second edge
    int          m_black;
    bit          m_ov;
    logic [15:0] m_sum;
    logic [15:0] m_a;
    logic [15:0] m_b;
    bit          m_prev;
    logic [31:0] cur_pair;

    task automatic model_reset();
        m_q.delete();
        m_fly = 0; m_stage = 0; m_black = 0; m_ov = 0;
        m_sum = '0; m_a = '0; m_b = '0; m_pair = '0;
        m_prev = 1;
    endtask

    function automatic logic [31:0] next_pair();
        logic [15:0] v[2];
        for (int k = 0; k < 2; k++) begin
            case ($urandom_range(0, 7))
                0: v[k] = 16'h7FC0;
                1: v[k] = 16'h7F80;
                2: v[k] = 16'hFF80;
                3: v[k] = 16'h8000;
                default: v[k] = 16'($urandom);
            endcase
        end
        return {v[0], v[1]};
    endfunction

    // Advance the model across one rising clock edge using the applied inputs.
    task automatic model_step(output bit accepted);
        bit edge_now;
        int pre_size;
        bit pre_fly;
        bit pre_ov;
        edge_now = add_ready && !m_prev;
        pre_size = m_q.size();
        pre_fly  = m_fly;
        pre_ov   = m_ov;
        accepted = in_valid && (pre_size < DEPTH);
        if (pre_ov && out_ready) m_ov = 0;
        if (pre_fly) begin
            if (m_stage == 0) begin
                if (edge_now) begin
                    m_stage = 1;
                    m_black = HOLD;
                end
            end else if (m_stage == 1) begin
                m_black--;
                if (m_black <= 0) m_stage = 2;
            end else if (edge_now) begin
                m_ov  = 1;
                m_sum = fake_sum(m_pair[31:16], m_pair[15:0]);
                m_fly = 0;
                n_results++;
                $display("result %0d: a=%h b=%h sum=%h", n_results, m_pair[31:16], m_pair[15:0], m_sum);
            end
        end else if (pre_size > 0 && !pre_ov) begin
            m_pair  = m_q.pop_front();
            m_a     = m_pair[31:16];
            m_b     = m_pair[15:0];
            m_fly   = 1;
            m_stage = 0;
        end
        if (accepted) m_q.push_back({in_a, in_b});
        m_prev = add_ready;
    endtask

    task automatic compare_all();
        check_eq("in_ready",  in_ready, (m_q.size() < DEPTH));
        check_eq("level",     level, m_q.size());
        check_eq("out_valid", out_valid, m_ov);
        check_eq("out_sum",   out_sum, m_sum);
        check_eq("add_a",     add_a, m_a);
        check_eq("add_b",     add_b, m_b);
        check_eq("busy",      busy, m_fly);
    endtask

    // One clock: apply inputs, predict, let the edge pass, compare 1 time unit later.
    task automatic tick(input bit v, input bit ar, input bit orr);
        bit acc;
        in_valid  = v;
        in_a      = cur_pair[31:16];
        in_b      = cur_pair[15:0];
        add_ready = ar;
        out_ready = orr;
        model_step(acc);
        @(posedge clock);
        #1;
        if (acc) cur_pair = next_pair();
        compare_all();
    endtask

    // Reset asserted between edges; outputs must clear without a clock.
    task automatic mid_cycle_reset();
        #3;
        reset     = 1'b1;
        in_valid  = 1'b0;
        add_ready = 1'b0;
        #1;
        check_eq("rst_out_valid", out_valid, 0);
        check_eq("rst_out_sum",   out_sum, 0);
        check_eq("rst_in_ready",  in_ready, 1);
        check_eq("rst_level",     level, 0);
        check_eq("rst_busy",      busy, 0);
        check_eq("rst_add_a",     add_a, 0);
        check_eq("rst_add_b",     add_b, 0);
        model_reset();
        #1;
        reset = 1'b0;
        @(posedge clock);
        #1;
    endtask

    initial begin
        int guard;
        model_reset();

        // Power-on reset, asserted before the first clock edge.
        #0;
        mid_cycle_reset();

        // Single operation: 1.0 + 2.0, adder pulses ready periodically.
        cur_pair = {16'h3F80, 16'h4000};
        tick(1, 0, 1);
        for (int i = 0; i < 30; i++) tick(0, (i % 6) == 2, 0);
        check_eq("single_sum", out_sum, 16'h4040);
        tick(0, 0, 1);

        // Fill the FIFO with the adder idle, then drain it.
        for (int i = 0; i < 8; i++) tick(1, 0, 1);
        check_eq("full_level", level, DEPTH);
        check_eq("full_in_ready", in_ready, 0);
        for (int i = 0; i < 80; i++) tick(i < 12, (i % 6) == 1, 1);

        // Back-pressure: consumer stalls with a second pair queued.
        tick(1, 0, 0);
        tick(1, 0, 0);
        for (int i = 0; i < 40; i++) tick(0, (i % 5) == 1, 0);
        for (int i = 0; i < 40; i++) tick(0, (i % 5) == 1, 1);

        // Ready held high across several cycles counts as a single edge.
        tick(1, 0, 1);
        for (int i = 0; i < 5; i++) tick(0, 1, 1);
        for (int i = 0; i < 10; i++) tick(0, 0, 1);
        check_eq("held_ready_no_result", out_valid, 0);
        for (int i = 0; i < 12; i++) tick(0, (i % 4) == 1, 1);

        // Reset while waiting for the result: nothing must come out afterwards.
        tick(1, 0, 1);
        tick(1, 0, 1);
        guard = 0;
        while (!(m_fly && m_stage == 2) && guard < 50) begin
            tick(0, (guard % 3) == 1, 1);
            guard++;
        end
        check_eq("reach_wait_result", (m_fly && m_stage == 2), 1);
        check_eq("busy_before_reset", busy, 1);
        mid_cycle_reset();
        for (int i = 0; i < 20; i++) tick(0, (i % 3) == 1, 1);

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            tick($urandom_range(0, 99) < 40,
                 $urandom_range(0, 99) < 30,
                 $urandom_range(0, 99) < 70);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
